// File: rtl/nv_nvdla_sdp_param_cq_if.sv
// rtl/nv_nvdla_sdp_param_cq_if.sv - valid/ready payload channel between SDP DMA stages and the context queue
interface nv_nvdla_sdp_param_cq_if #(
    parameter int WIDTH = 16
);
    logic             pvld;
    logic             prdy;
    logic [WIDTH-1:0] pd;

    modport master (output pvld, output pd, input prdy);
    modport slave  (input pvld, input pd, output prdy);
endinterface

// File: rtl/nv_nvdla_sdp_param_cq.sv
// rtl/nv_nvdla_sdp_param_cq.sv - parametrised SDP read-DMA context queue with write limit, occupancy and flush
module nv_nvdla_sdp_param_cq #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 80,
    parameter int AW        = $clog2(DEPTH),
    parameter int CW        = $clog2(DEPTH + 1),
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    flush,
    input  logic [CW-1:0]           wr_limit,
    nv_nvdla_sdp_param_cq_if.slave  ig2cq,
    nv_nvdla_sdp_param_cq_if.master cq2eg,
    output logic [CW-1:0]           wr_count,
    output logic                    almost_full,
    input  logic [31:0]             pwrbus_ram_pd
);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             ig2cq_prdy_r;
    logic             cq2eg_pvld_r;
    logic [WIDTH-1:0] cq2eg_pd_r;
    logic             wr_push;
    logic             wr_push_d;
    logic             rd_pop;
    logic             rd_pop_d;
    logic             rd_req;
    logic [CW-1:0]    wr_count_next;
    logic [CW-1:0]    rd_count;
    logic [CW-1:0]    rd_count_next;
    logic             clear;
    logic             unused_pwrbus;

    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign clear      = nvdla_core_rst | flush;
    assign wr_push    = ig2cq.pvld & ig2cq_prdy_r;
    assign rd_pop     = cq2eg_pvld_r & cq2eg.prdy;
    assign ig2cq.prdy = ig2cq_prdy_r;
    assign cq2eg.pvld = cq2eg_pvld_r;
    assign cq2eg.pd   = cq2eg_pd_r;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Pops reach the write-side count a cycle late, so a slot is only reused once its data has left the RAM.
    always_comb begin
        wr_count_next = wr_count;
        if (wr_push && !rd_pop_d) begin
            wr_count_next = wr_count + ONE_C;
        end else if (!wr_push && rd_pop_d) begin
            wr_count_next = wr_count - ONE_C;
        end
    end

    // The output register is the RAM read register; refill it whenever it is empty or being drained.
    assign rd_req = ((rd_count != '0) || wr_push_d) && (!cq2eg_pvld_r || rd_pop);

    always_comb begin
        rd_count_next = rd_count;
        if (wr_push_d && !rd_req) begin
            rd_count_next = rd_count + ONE_C;
        end else if (!wr_push_d && rd_req) begin
            rd_count_next = rd_count - ONE_C;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (clear) begin
            wr_ptr       <= '0;
            wr_count     <= '0;
            ig2cq_prdy_r <= 1'b1;
            almost_full  <= 1'b0;
            rd_pop_d     <= 1'b0;
            wr_push_d    <= 1'b0;
        end else begin
            if (wr_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            wr_count     <= wr_count_next;
            ig2cq_prdy_r <= !((wr_count_next == DEPTH_C) ||
                              ((wr_limit != '0) && (wr_count_next >= wr_limit)));
            almost_full  <= (wr_count_next >= AFULL_C);
            rd_pop_d     <= rd_pop;
            wr_push_d    <= wr_push;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (wr_push && !clear) begin
            mem[wr_ptr] <= ig2cq.pd;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (clear) begin
            rd_ptr       <= '0;
            rd_count     <= '0;
            cq2eg_pvld_r <= 1'b0;
        end else begin
            rd_count <= rd_count_next;
            if (rd_req) begin
                rd_ptr       <= ptr_inc(rd_ptr);
                cq2eg_pvld_r <= 1'b1;
            end else if (rd_pop) begin
                cq2eg_pvld_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (rd_req && !clear) begin
            cq2eg_pd_r <= mem[rd_ptr];
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_stalled: assert property (@(posedge nvdla_core_clk) disable iff (clear)
        !ig2cq_prdy_r |=> (wr_count <= $past(wr_count)));

    a_count_bound: assert property (@(posedge nvdla_core_clk)
        wr_count <= DEPTH_C);

    a_stall_stable: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        (cq2eg_pvld_r && !cq2eg.prdy && !flush) |=> ($stable(cq2eg_pd_r) && $stable(rd_ptr) && cq2eg_pvld_r));
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_param_cq.sv
// tb/tb_nv_nvdla_sdp_param_cq.sv - randomized scoreboard bench for the SDP context queue
module tb_nv_nvdla_sdp_param_cq;
    localparam int DEPTH = 80;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AFULL = DEPTH - 2;
    localparam int D3    = 3;
    localparam int W3    = 8;
    localparam int CW3   = $clog2(D3 + 1);
    localparam int AF3   = 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             flush3;
    logic [CW-1:0]    wr_limit;
    logic [CW3-1:0]   wr_limit3;
    logic [CW-1:0]    wr_count;
    logic [CW3-1:0]   wr_count3;
    logic             almost_full;
    logic             almost_full3;
    logic [31:0]      pwrbus;

    nv_nvdla_sdp_param_cq_if #(.WIDTH(WIDTH)) ig ();
    nv_nvdla_sdp_param_cq_if #(.WIDTH(WIDTH)) cq ();
    nv_nvdla_sdp_param_cq_if #(.WIDTH(W3))    ig3 ();
    nv_nvdla_sdp_param_cq_if #(.WIDTH(W3))    cq3 ();

    nv_nvdla_sdp_param_cq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .flush          (flush),
        .wr_limit       (wr_limit),
        .ig2cq          (ig),
        .cq2eg          (cq),
        .wr_count       (wr_count),
        .almost_full    (almost_full),
        .pwrbus_ram_pd  (pwrbus)
    );

    nv_nvdla_sdp_param_cq #(.WIDTH(W3), .DEPTH(D3), .AFULL_LVL(AF3)) u_dut3 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .flush          (flush3),
        .wr_limit       (wr_limit3),
        .ig2cq          (ig3),
        .cq2eg          (cq3),
        .wr_count       (wr_count3),
        .almost_full    (almost_full3),
        .pwrbus_ram_pd  (pwrbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] m_q[$];
    int               m_cnt;
    bit               m_pop_d;
    logic [W3-1:0]    m3_q[$];
    int               m3_cnt;
    bit               m3_pop_d;
    int               n_vec;
    int               n_err;

    function automatic bit exp_prdy(input int cnt, input int lim, input int dep);
        return !(cnt == dep || (lim != 0 && cnt >= lim));
    endfunction

    // One clock of the 80-deep queue: drive, predict, advance to 1ns past the edge.
    task automatic step(input bit pv, input logic [WIDTH-1:0] d, input bit rr, input bit fl, input bit rs,
                        output bit popped, output logic [WIDTH-1:0] got, output logic [WIDTH-1:0] exp);
        bit push;
        bit pop;
        ig.pvld = pv;
        ig.pd   = d;
        cq.prdy = rr;
        flush   = fl;
        rst     = rs;
        push    = pv && ig.prdy;
        pop     = cq.pvld && rr;
        popped  = 1'b0;
        got     = cq.pd;
        exp     = 'x;
        if (fl || rs) begin
            m_q.delete();
            m_cnt   = 0;
            m_pop_d = 1'b0;
        end else begin
            if (pop) begin
                popped = 1'b1;
                if (m_q.size() != 0) exp = m_q.pop_front();
            end
            if (push) m_q.push_back(d);
            m_cnt   = m_cnt + int'(push) - int'(m_pop_d);
            m_pop_d = pop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input bit pv, input logic [W3-1:0] d, input bit rr, input bit fl,
                         output bit popped, output logic [W3-1:0] got, output logic [W3-1:0] exp);
        bit push;
        bit pop;
        ig3.pvld = pv;
        ig3.pd   = d;
        cq3.prdy = rr;
        flush3   = fl;
        push     = pv && ig3.prdy;
        pop      = cq3.pvld && rr;
        popped   = 1'b0;
        got      = cq3.pd;
        exp      = 'x;
        if (fl) begin
            m3_q.delete();
            m3_cnt   = 0;
            m3_pop_d = 1'b0;
        end else begin
            if (pop) begin
                popped = 1'b1;
                if (m3_q.size() != 0) exp = m3_q.pop_front();
            end
            if (push) m3_q.push_back(d);
            m3_cnt   = m3_cnt + int'(push) - int'(m3_pop_d);
            m3_pop_d = pop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit p;
        logic [WIDTH-1:0] g, e;
        repeat (2) step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, p, g, e);
        n_vec++; if (ig.prdy !== 1'b1) begin n_err++; $display("FAIL reset_prdy got=%b want=1", ig.prdy); end
        n_vec++; if (cq.pvld !== 1'b0) begin n_err++; $display("FAIL reset_pvld got=%b want=0", cq.pvld); end
        n_vec++; if (wr_count !== '0) begin n_err++; $display("FAIL reset_count got=%0d want=0", wr_count); end
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got=%b want=0", almost_full); end
        n_vec++; if (ig3.prdy !== 1'b1 || cq3.pvld !== 1'b0 || wr_count3 !== '0 || almost_full3 !== 1'b0) begin
            n_err++; $display("FAIL reset_dut3 got prdy=%b pvld=%b cnt=%0d af=%b want 1/0/0/0",
                              ig3.prdy, cq3.pvld, wr_count3, almost_full3);
        end
    endtask

    task automatic test_latency();
        bit p;
        bit want_v;
        logic [WIDTH-1:0] g, e;
        int peak;
        peak = 0;
        wr_limit = '0;
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, p, g, e);
        for (int c = 0; c < 10; c++) begin
            want_v = (c >= 2 && c <= 6);
            n_vec++;
            if (cq.pvld !== want_v) begin n_err++; $display("FAIL latency_pvld c=%0d got=%b want=%b", c, cq.pvld, want_v); end
            if (want_v) begin
                n_vec++;
                if (cq.pd !== 16'(c - 1)) begin n_err++; $display("FAIL latency_pd c=%0d got=%h want=%h", c, cq.pd, 16'(c - 1)); end
            end
            step(c < 5, 16'(c + 1), 1'b1, 1'b0, 1'b0, p, g, e);
            if (int'(wr_count) > peak) peak = int'(wr_count);
        end
        n_vec++; if (peak != 3) begin n_err++; $display("FAIL latency_peak got=%0d want=3", peak); end
    endtask

    task automatic test_full();
        bit p;
        int guard;
        logic [WIDTH-1:0] g, e;
        wr_limit = '0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, p, g, e);
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (ig.prdy !== 1'b1) begin n_err++; $display("FAIL full_prdy_early i=%0d got=%b want=1", i, ig.prdy); end
            step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, p, g, e);
        end
        n_vec++; if (ig.prdy !== 1'b0) begin n_err++; $display("FAIL full_prdy got=%b want=0", ig.prdy); end
        n_vec++; if (wr_count !== CW'(DEPTH)) begin n_err++; $display("FAIL full_count got=%0d want=%0d", wr_count, DEPTH); end
        n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_afull got=%b want=1", almost_full); end
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, p, g, e);
        n_vec++; if (!p || g !== e) begin n_err++; $display("FAIL full_pop_data got=%h want=%h popped=%b", g, e, p); end
        n_vec++; if (ig.prdy !== 1'b0) begin n_err++; $display("FAIL full_prdy_n1 got=%b want=0", ig.prdy); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, p, g, e);
        n_vec++; if (ig.prdy !== 1'b1) begin n_err++; $display("FAIL full_prdy_n2 got=%b want=1", ig.prdy); end
        n_vec++; if (wr_count !== CW'(DEPTH - 1)) begin n_err++; $display("FAIL full_count_n2 got=%0d want=%0d", wr_count, DEPTH - 1); end
        guard = 0;
        while (m_q.size() != 0 && guard < 300) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
            if (p) begin
                n_vec++; if (g !== e) begin n_err++; $display("FAIL full_drain_data got=%h want=%h", g, e); end
            end
            guard++;
        end
        n_vec++; if (m_q.size() != 0) begin n_err++; $display("FAIL full_drain_timeout left=%0d want=0", m_q.size()); end
    endtask

    task automatic test_limit_wrap();
        bit p;
        bit pv;
        bit rr;
        int sent;
        int guard;
        logic [WIDTH-1:0] g, e, d;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, p, g, e);
        wr_limit = CW'(5);
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, p, g, e);
        n_vec++; if (wr_count !== CW'(5)) begin n_err++; $display("FAIL limit_count got=%0d want=5", wr_count); end
        n_vec++; if (ig.prdy !== 1'b0) begin n_err++; $display("FAIL limit_prdy got=%b want=0", ig.prdy); end
        wr_limit = '0;
        sent  = 0;
        guard = 0;
        while (sent < 300 && guard < 5000) begin
            pv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 1) != 0);
            d  = WIDTH'($urandom);
            if (pv && ig.prdy) sent++;
            step(pv, d, rr, 1'b0, 1'b0, p, g, e);
            if (p) begin
                n_vec++; if (g !== e) begin n_err++; $display("FAIL wrap_data got=%h want=%h", g, e); end
            end
            n_vec++; if (wr_count !== CW'(m_cnt)) begin n_err++; $display("FAIL wrap_count got=%0d want=%0d", wr_count, m_cnt); end
            n_vec++; if (ig.prdy !== exp_prdy(m_cnt, 0, DEPTH)) begin n_err++; $display("FAIL wrap_prdy got=%b want=%b", ig.prdy, exp_prdy(m_cnt, 0, DEPTH)); end
            n_vec++; if (almost_full !== (m_cnt >= AFULL)) begin n_err++; $display("FAIL wrap_afull got=%b want=%b", almost_full, m_cnt >= AFULL); end
            guard++;
        end
        n_vec++; if (sent != 300) begin n_err++; $display("FAIL wrap_timeout sent=%0d want=300", sent); end
        guard = 0;
        while (m_q.size() != 0 && guard < 500) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
            if (p) begin
                n_vec++; if (g !== e) begin n_err++; $display("FAIL wrap_drain_data got=%h want=%h", g, e); end
            end
            guard++;
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
        n_vec++; if (cq.pvld !== 1'b0 || wr_count !== '0) begin
            n_err++; $display("FAIL wrap_empty got pvld=%b cnt=%0d want 0/0", cq.pvld, wr_count);
        end
    endtask

    task automatic test_stall();
        bit p;
        int guard;
        logic [WIDTH-1:0] g, e;
        wr_limit = '0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, p, g, e);
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, p, g, e);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (cq.pvld !== 1'b1 || cq.pd !== m_q[0]) begin
                n_err++; $display("FAIL stall_hold i=%0d got pvld=%b pd=%h want 1/%h", i, cq.pvld, cq.pd, m_q[0]);
            end
            step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, p, g, e);
        end
        guard = 0;
        while (m_q.size() != 0 && guard < 100) begin
            n_vec++; if (cq.pvld !== 1'b1) begin n_err++; $display("FAIL stall_gap left=%0d got=%b want=1", m_q.size(), cq.pvld); end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
            n_vec++; if (g !== e) begin n_err++; $display("FAIL stall_drain_data got=%h want=%h", g, e); end
            guard++;
        end
        n_vec++; if (m_q.size() != 0) begin n_err++; $display("FAIL stall_timeout left=%0d want=0", m_q.size()); end
    endtask

    task automatic test_flush_reset();
        bit p;
        int guard;
        logic [WIDTH-1:0] g, e;
        wr_limit = '0;
        for (int mode = 0; mode < 2; mode++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, p, g, e);
            for (int i = 0; i < 6; i++) step(1'b1, WIDTH'($urandom) & 16'h7fff, 1'b0, 1'b0, 1'b0, p, g, e);
            repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, p, g, e);
            n_vec++; if (wr_count !== CW'(6)) begin n_err++; $display("FAIL flush_pre_count mode=%0d got=%0d want=6", mode, wr_count); end
            step(1'b1, 16'hDEAD, 1'b1, mode == 0, mode == 1, p, g, e);
            n_vec++;
            if (wr_count !== '0 || cq.pvld !== 1'b0 || ig.prdy !== 1'b1 || almost_full !== 1'b0) begin
                n_err++; $display("FAIL flush_state mode=%0d got cnt=%0d pvld=%b prdy=%b af=%b want 0/0/1/0",
                                  mode, wr_count, cq.pvld, ig.prdy, almost_full);
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
                n_vec++; if (cq.pvld !== 1'b0) begin n_err++; $display("FAIL flush_stale mode=%0d i=%0d got=%b want=0", mode, i, cq.pvld); end
            end
            for (int i = 0; i < 20; i++) begin
                step($urandom_range(0, 1) != 0, WIDTH'($urandom) & 16'h7fff, 1'b1, 1'b0, 1'b0, p, g, e);
                if (p) begin
                    n_vec++; if (g !== e || g === 16'hDEAD) begin n_err++; $display("FAIL flush_after_data mode=%0d got=%h want=%h", mode, g, e); end
                end
            end
            guard = 0;
            while (m_q.size() != 0 && guard < 50) begin
                step(1'b0, '0, 1'b1, 1'b0, 1'b0, p, g, e);
                if (p) begin
                    n_vec++; if (g !== e) begin n_err++; $display("FAIL flush_drain_data mode=%0d got=%h want=%h", mode, g, e); end
                end
                guard++;
            end
            n_vec++; if (m_q.size() != 0) begin n_err++; $display("FAIL flush_timeout mode=%0d left=%0d want=0", mode, m_q.size()); end
        end
    endtask

    task automatic test_npot();
        bit p;
        bit rr;
        int sent;
        int popped_n;
        int guard;
        logic [W3-1:0] g, e;
        ig.pvld  = 1'b0;
        cq.prdy  = 1'b0;
        wr_limit3 = '0;
        step3(1'b0, '0, 1'b0, 1'b1, p, g, e);
        sent     = 0;
        popped_n = 0;
        guard    = 0;
        while ((sent < 256 || m3_q.size() != 0) && guard < 3000) begin
            rr = (guard < 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (sent < 256 && ig3.prdy) begin
                step3(1'b1, W3'(sent), rr, 1'b0, p, g, e);
                sent++;
            end else begin
                step3(sent < 256, W3'(sent), rr, 1'b0, p, g, e);
            end
            if (p) begin
                popped_n++;
                n_vec++; if (g !== e) begin n_err++; $display("FAIL npot_data got=%h want=%h", g, e); end
            end
            n_vec++;
            if (wr_count3 !== CW3'(m3_cnt) || int'(wr_count3) > D3) begin
                n_err++; $display("FAIL npot_count got=%0d want=%0d", wr_count3, m3_cnt);
            end
            n_vec++; if (almost_full3 !== (m3_cnt >= AF3)) begin n_err++; $display("FAIL npot_afull got=%b want=%b", almost_full3, m3_cnt >= AF3); end
            n_vec++; if (ig3.prdy !== exp_prdy(m3_cnt, 0, D3)) begin n_err++; $display("FAIL npot_prdy got=%b want=%b", ig3.prdy, exp_prdy(m3_cnt, 0, D3)); end
            guard++;
        end
        n_vec++; if (popped_n != 256) begin n_err++; $display("FAIL npot_total got=%0d want=256", popped_n); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_cnt     = 0;
        m_pop_d   = 1'b0;
        m3_cnt    = 0;
        m3_pop_d  = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        flush3    = 1'b0;
        wr_limit  = '0;
        wr_limit3 = '0;
        pwrbus    = $urandom;
        ig.pvld   = 1'b0;
        ig.pd     = '0;
        cq.prdy   = 1'b0;
        ig3.pvld  = 1'b0;
        ig3.pd    = '0;
        cq3.prdy  = 1'b0;
        test_reset();
        test_latency();
        test_full();
        test_limit_wrap();
        test_stall();
        test_flush_reset();
        test_npot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nv_nvdla_sdp_param_cq.md
Name: nv_nvdla_sdp_param_cq

Overview:
- Parametrised synchronous context-queue FIFO for SDP read-DMA paths. It generalises the fixed 80x16 command queue to any width and depth.
- Adds three things the fixed queue lacks:
  - a runtime write-limit input;
  - an occupancy output and almost-full flag;
  - a synchronous flush.
- It sits between the DMA ingress (ig2cq) and egress (cq2eg) stages, using valid/ready handshakes on both sides.
- Storage is an internal behavioural RAM with a registered read (1-cycle read latency) and a prefetching output stage.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- DEPTH, 80, number of entries (>=2; need not be a power of two).
- AW, $clog2(DEPTH), address width (derived; do not override).
- CW, $clog2(DEPTH+1), count width (derived; do not override).
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts.

Ports:
- nvdla_core_clk  in  1  sole clock; all flops on posedge.
- nvdla_core_rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous queue clear, one-cycle pulse or level.
- wr_limit  in  CW  runtime capacity cap; 0 = use DEPTH; quasi-static.
- ig2cq_pvld  in  1  write valid.
- ig2cq_prdy  out  1  write ready (registered).
- ig2cq_pd  in  WIDTH  write payload.
- cq2eg_pvld  out  1  read valid (registered).
- cq2eg_prdy  in  1  read ready.
- cq2eg_pd  out  WIDTH  read payload.
- wr_count  out  CW  write-side occupancy (registered).
- almost_full  out  1  registered; wr_count_next >= AFULL_LVL.
- pwrbus_ram_pd  in  32  RAM power-down bus; no functional effect in behavioural RAM.

Behaviour:
- Reset (nvdla_core_rst=1 at a clock edge):
  - values after the edge: ig2cq_prdy=1, cq2eg_pvld=0, wr_count=0, almost_full=0;
  - write/read pointers = 0; RAM contents untouched.
- Reset applied mid-operation discards all queued data, and the same edge sets the values above.
- Push = ig2cq_pvld & ig2cq_prdy. Data is written at the write pointer the same cycle.
- Pop = cq2eg_pvld & cq2eg_prdy.
- Pointers increment modulo DEPTH (DEPTH-1 wraps to 0). No pointer overflow is possible.
- Write side:
  - wr_count +1 on a push;
  - wr_count -1 one cycle after a pop (registered pop crossing);
  - both in the same cycle leave it unchanged.
- ig2cq_prdy register:
  - next value = !(wr_count_next == DEPTH || (wr_limit != 0 && wr_count_next >= wr_limit));
  - ig2cq_prdy is never driven combinationally from inputs.
- A wr_limit smaller than the current occupancy only stalls writes; no data is dropped.
- Read side:
  - the write-to-read notice is delayed one cycle (data lands in RAM first);
  - a read count tracks entries;
  - a RAM read is issued whenever entries exist and the output stage is empty or popping.
- Latency: a push into an empty queue at cycle N gives cq2eg_pvld=1 with that data at cycle N+2.
- Back-to-back throughput is 1 entry/cycle on both sides.
- Output stability: while cq2eg_pvld=1 and cq2eg_prdy=0, cq2eg_pd and cq2eg_pvld hold. The RAM read address must not advance.
- Full recovery: with the queue full and a pop at cycle N, ig2cq_prdy=1 at cycle N+2.
- Simultaneous push and pop at any occupancy keeps wr_count constant and preserves order.
- Flush:
  - priority is reset > flush > push/pop;
  - an asserted flush behaves exactly like reset for pointers, counts and flags on the next edge;
  - a push or pop in the flush cycle is discarded and not counted;
  - in-flight RAM reads are invalidated, so no stale data appears after the flush;
  - ig2cq_prdy=1 and cq2eg_pvld=0 the cycle after the flush.
- Ordering is strict FIFO; no data is duplicated or lost outside reset/flush.
- Assertions (sim only):
  - no push when ig2cq_prdy=0 is accepted;
  - wr_count <= DEPTH;
  - cq2eg_pd stable under stall.

Test Plan:
- Latency/order: DEPTH=80, push 0x0001..0x0005 on cycles 10..14, cq2eg_prdy=1 → cq2eg_pvld high cycles 12..16, with pd 0x0001..0x0005 in order; wr_count peaks at 3.
- Full/recovery: DEPTH=80, cq2eg_prdy=0, push 80 words → ig2cq_prdy=0 after the 80th push and wr_count=80; one pop at cycle N → ig2cq_prdy=1 at N+2 and wr_count=79.
- Limit/wrap:
  - wr_limit=5, stall reads → ig2cq_prdy drops when wr_count=5;
  - then stream 300 words with random prdy → output matches the input sequence across pointer wrap 79→0.
- Non-power-of-two: DEPTH=3, WIDTH=8, continuous push/pop of 0x00..0xFF → in-order data, wr_count never exceeds 3, almost_full (AFULL_LVL=1) asserted while count>=1.
- Stall stability: pvld=1 with prdy=0 held 10 cycles while pushes continue → cq2eg_pd constant; after release, data drains in order with no gaps.
- Flush/reset mid-stream:
  - 6 entries queued, flush with a simultaneous push → next cycle wr_count=0, cq2eg_pvld=0, ig2cq_prdy=1; the flushed push never appears at the output;
  - repeat with nvdla_core_rst → identical result.
